// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V commit-trace monitor: widths, halt
// instructions, halt-cause codes and monitor FSM state encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_LOOP    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True for the two environment-call instructions that end a program.
  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/riscv_trace_monitor_if.sv
// Commit stream from the core plus the trace read-out port (pop / oldest entry).
interface riscv_trace_monitor_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  import riscv_pkg::*;

  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic            commit_rd_we;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_rd_data;
  logic            pop;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_rd_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_rd_data;

  // Master: the core/bench side that retires instructions and drains the trace.
  modport master (
    output commit_valid, commit_pc, commit_instr, commit_rd_we, commit_rd, commit_rd_data, pop,
    input  out_valid, out_pc, out_instr, out_rd_we, out_rd, out_rd_data
  );

  // Slave: the monitor itself.
  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_rd_we, commit_rd, commit_rd_data, pop,
    output out_valid, out_pc, out_instr, out_rd_we, out_rd, out_rd_data
  );
endinterface

// File: rtl/riscv_trace_monitor_fifo.sv
// Circular trace buffer: overwrite-oldest on full, combinational head read,
// simultaneous push/pop, synchronous clear for re-arming.
module trace_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, do_pop;

  // Pointer/count update; a push into a full buffer without a pop drops the oldest entry.
  always_comb begin
    full       = (count_q == FULL_CNT);
    do_pop     = pop && (count_q != '0);
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (do_pop || (push && full)) head_d = head_q + 1'b1;
      if (push && full && !do_pop) overflow_d = 1'b1;
      if (push && !do_pop && !full) count_d = count_q + 1'b1;
      else if (!push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[tail_q] <= wdata;
  end

  // Pointer, count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = (count_q != '0);
  assign rdata    = valid ? mem_q[head_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/riscv_trace_monitor.sv
// Commit-trace monitor: records retired instructions, detects program end
// (ECALL/EBREAK, self-loop, timeout) and counts RUN cycles and retirements.
module riscv_trace_monitor import riscv_pkg::*; #(
  parameter int XLEN           = riscv_pkg::XLEN,
  parameter int DEPTH          = 16,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  riscv_trace_monitor_if.slave   mon,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [31:0]            cycle_count,
  output logic [31:0]            retire_count
);
  localparam int EW = XLEN + 32 + 1 + 5 + XLEN;
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LIMIT = RW'(HALT_REPEAT);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     cycle_q, cycle_d;
  logic [31:0]     retire_q, retire_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            last_valid_q, last_valid_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            fifo_clear, fifo_push;
  logic [EW-1:0]   fifo_wdata, fifo_rdata;

  // FSM, counters and halt detection (priority ECALL/EBREAK > self-loop > timeout).
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cycle_d      = cycle_q;
    retire_d     = retire_q;
    idle_d       = idle_q;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    rep_d        = rep_q;
    fifo_clear   = 1'b0;
    fifo_push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_RUN;
          fifo_clear   = 1'b1;
          cause_d      = CAUSE_NONE;
          cycle_d      = '0;
          retire_d     = '0;
          idle_d       = '0;
          last_valid_d = 1'b0;
          rep_d        = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          cycle_d = cycle_q + 32'd1;
          if (mon.commit_valid) begin
            fifo_push    = 1'b1;
            retire_d     = retire_q + 32'd1;
            idle_d       = '0;
            last_pc_d    = mon.commit_pc;
            last_valid_d = 1'b1;
            rep_d        = (last_valid_q && mon.commit_pc == last_pc_q) ? rep_q + 1'b1 : RW'(1);
            if (is_halt_instr(mon.commit_instr)) begin
              state_d = ST_DONE;
              cause_d = CAUSE_ECALL;
            end else if (rep_d == REP_LIMIT) begin
              state_d = ST_DONE;
              cause_d = CAUSE_LOOP;
            end
          end else begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_LIMIT) begin
              state_d = ST_DONE;
              cause_d = CAUSE_TIMEOUT;
            end
          end
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cause_q      <= CAUSE_NONE;
      cycle_q      <= '0;
      retire_q     <= '0;
      idle_q       <= '0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
      rep_q        <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
      idle_q       <= idle_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
      rep_q        <= rep_d;
    end
  end

  // Writes to x0 are architecturally dropped, so the trace records them as no-write.
  assign fifo_wdata = {mon.commit_pc, mon.commit_instr,
                       mon.commit_rd_we && (mon.commit_rd != 5'd0),
                       mon.commit_rd, mon.commit_rd_data};

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .pop      (mon.pop),
    .wdata    (fifo_wdata),
    .rdata    (fifo_rdata),
    .valid    (mon.out_valid),
    .count    (count),
    .overflow (overflow)
  );

  assign {mon.out_pc, mon.out_instr, mon.out_rd_we, mon.out_rd, mon.out_rd_data} = fifo_rdata;
  assign halted       = (state_q == ST_DONE);
  assign halt_cause   = cause_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
endmodule
